adc_smooth: RTL and testbench

ADC_SMOOTH -- requirements
Module: adc_smooth

---
 rtl/adc_smooth.sv | 195 +++++++++++++++++++
 tb/tb_adc_smooth.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_smooth.sv
// adc_smooth: moving-average smoother for a raw unsigned ADC stream.
// A HIST-deep sample history and a running sum give a boxcar average over
// the last 2^k samples, where k is the configured window exponent.
// The block must see a full window of samples before it produces output.
// Any window change or disable empties the history and starts a new fill.
module adc_smooth #(
  parameter int W_IN = 12,
  parameter int HIST = 8
) (
  input  logic            clk_sys,
  input  logic            rst,
  input  logic [W_IN-1:0] adc_data,
  input  logic            adc_vld,
  input  logic            cfg_en,
  input  logic [1:0]      cfg_shift,
  output logic [15:0]     sm_data,
  output logic            sm_vld,
  output logic [1:0]      stu_state,
  output logic [7:0]      stu_drop
);

  localparam int IDX_W = $clog2(HIST);
  localparam int SUM_W = W_IN + IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // History slot holding the oldest sample of a 2^k window (index N-1).
  function automatic logic [IDX_W-1:0] tail_idx(input logic [1:0] k);
    logic [IDX_W-1:0] idx;
    case (k)
      2'd0:    idx = IDX_W'(0);
      2'd1:    idx = IDX_W'(1);
      2'd2:    idx = IDX_W'(3);
      2'd3:    idx = IDX_W'(7);
      default: idx = IDX_W'(HIST - 1);
    endcase
    return idx;
  endfunction

  state_t              state_r;
  state_t              state_s;
  logic [W_IN-1:0]     hist_r [HIST];
  logic [SUM_W-1:0]    sum_r;
  logic [SUM_W-1:0]    sum_nxt_s;
  logic [IDX_W-1:0]    fill_r;
  logic [IDX_W-1:0]    tail_s;
  logic [1:0]          shift_q_r;
  logic [15:0]         sm_data_r;
  logic                sm_vld_r;
  logic [7:0]          drop_r;

  logic                clr_s;
  logic                accept_s;
  logic                emit_s;
  logic                drop_s;
  logic                load_k_s;
  logic                fill_inc_s;

  // Window tail index and running sum after accepting the current sample.
  // The subtracted slot is always part of the sum, so the difference never
  // goes negative; during fill that slot is still zero from the last clear.
  always_comb begin
    tail_s    = tail_idx(shift_q_r);
    sum_nxt_s = sum_r + SUM_W'(adc_data) - SUM_W'(hist_r[tail_s]);
  end

  // Next-state and control decode: disable beats window change, which beats
  // sample acceptance.
  always_comb begin
    state_s    = state_r;
    clr_s      = 1'b0;
    accept_s   = 1'b0;
    emit_s     = 1'b0;
    drop_s     = 1'b0;
    load_k_s   = 1'b0;
    fill_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clr_s    = 1'b1;
        load_k_s = 1'b1;
        if (cfg_en) begin
          state_s = ST_FILL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL, ST_RUN: begin
        if (!cfg_en) begin
          state_s = ST_IDLE;
          clr_s   = 1'b1;
        end else if (cfg_shift != shift_q_r) begin
          state_s  = ST_FILL;
          clr_s    = 1'b1;
          load_k_s = 1'b1;
          drop_s   = adc_vld;
        end else if (adc_vld) begin
          accept_s = 1'b1;
          if (state_r == ST_RUN) begin
            emit_s = 1'b1;
          end else if (fill_r == tail_s) begin
            emit_s  = 1'b1;
            state_s = ST_RUN;
          end else begin
            fill_inc_s = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        clr_s   = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Sample history: newest sample enters at index 0.
  always_ff @(posedge clk_sys) begin
    if (rst || clr_s) begin
      for (int i = 0; i < HIST; i++) begin
        hist_r[i] <= {W_IN{1'b0}};
      end
    end else if (accept_s) begin
      hist_r[0] <= adc_data;
      for (int i = 1; i < HIST; i++) begin
        hist_r[i] <= hist_r[i-1];
      end
    end
  end

  // Running sum and fill counter.
  always_ff @(posedge clk_sys) begin
    if (rst || clr_s) begin
      sum_r  <= {SUM_W{1'b0}};
      fill_r <= {IDX_W{1'b0}};
    end else begin
      if (accept_s) begin
        sum_r <= sum_nxt_s;
      end
      if (fill_inc_s) begin
        fill_r <= fill_r + IDX_W'(1);
      end
    end
  end

  // Registered window exponent; follows the input while idle or on a change.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      shift_q_r <= 2'd0;
    end else if (load_k_s) begin
      shift_q_r <= cfg_shift;
    end
  end

  // Averaged output: one-cycle pulse, data held between pulses.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sm_vld_r  <= 1'b0;
      sm_data_r <= 16'd0;
    end else begin
      sm_vld_r <= emit_s;
      if (emit_s) begin
        sm_data_r <= 16'(sum_nxt_s >> shift_q_r);
      end
    end
  end

  // Saturating count of samples lost to window changes.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      drop_r <= 8'd0;
    end else if (drop_s && (drop_r != 8'd255)) begin
      drop_r <= drop_r + 8'd1;
    end
  end

  assign sm_data   = sm_data_r;
  assign sm_vld    = sm_vld_r;
  assign stu_state = state_r;
  assign stu_drop  = drop_r;

endmodule

// File: tb/tb_adc_smooth.sv
// tb_adc_smooth: randomized and directed stimulus for adc_smooth, checked by a
// scoreboard fed from a window-average reference model.
module tb_adc_smooth;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] adc_data = 12'd0;
  logic        adc_vld = 1'b0;
  logic        cfg_en = 1'b0;
  logic [1:0]  cfg_shift = 2'd0;
  logic [15:0] sm_data;
  logic        sm_vld;
  logic [1:0]  stu_state;
  logic [7:0]  stu_drop;

  adc_smooth #(.W_IN(12), .HIST(8)) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .adc_data (adc_data),
    .adc_vld  (adc_vld),
    .cfg_en   (cfg_en),
    .cfg_shift(cfg_shift),
    .sm_data  (sm_data),
    .sm_vld   (sm_vld),
    .stu_state(stu_state),
    .stu_drop (stu_drop)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int unsigned edge_no;
    int unsigned data;
  } out_t;

  typedef struct {
    int unsigned edge_no;
    int unsigned state;
    int unsigned drop;
    bit          after_rst;
  } snap_t;

  out_t        out_q[$];
  snap_t       snap_q[$];
  int unsigned edge_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          done = 1'b0;

  // Reference model: list of samples since the last clear, newest first.
  int unsigned m_state = 0;
  int unsigned m_drop = 0;
  int unsigned m_k = 0;
  int unsigned m_samples[$];

  out_t  mo;
  snap_t ms;

  // Clock edge counter used to time-stamp expectations.
  always @(posedge clk_sys) edge_cnt <= edge_cnt + 1;

  // Drive one cycle of inputs and record what the model expects after the edge.
  task automatic step(input bit r, input bit en, input bit v,
                      input int unsigned d, input int unsigned k);
    out_t  o;
    snap_t s;
    int unsigned n;
    int unsigned acc;
    rst       = r;
    cfg_en    = en;
    adc_vld   = v;
    adc_data  = d[11:0];
    cfg_shift = k[1:0];
    if (r) begin
      m_state = 0; m_drop = 0; m_k = 0; m_samples.delete();
    end else if (m_state == 0) begin
      m_k = k; m_samples.delete();
      if (en) m_state = 1;
    end else if (!en) begin
      m_state = 0; m_samples.delete();
    end else if (k != m_k) begin
      m_k = k; m_samples.delete(); m_state = 1;
      if (v && m_drop < 255) m_drop++;
    end else if (v) begin
      n = 1 << m_k;
      m_samples.push_front(d);
      if (m_samples.size() > 8) void'(m_samples.pop_back());
      if (m_state == 1 && m_samples.size() == n) m_state = 2;
      if (m_state == 2) begin
        acc = 0;
        for (int i = 0; i < n; i++) acc += m_samples[i];
        o.edge_no = edge_cnt + 1;
        o.data    = acc >> m_k;
        out_q.push_back(o);
      end
    end
    s.edge_no   = edge_cnt + 1;
    s.state     = m_state;
    s.drop      = m_drop;
    s.after_rst = r;
    snap_q.push_back(s);
    @(posedge clk_sys);
    #1;
  endtask

  // Monitor: compares DUT outputs against queued expectations each cycle.
  always @(negedge clk_sys) begin
    if (snap_q.size() > 0 && snap_q[0].edge_no == edge_cnt) begin
      ms = snap_q.pop_front();
      n_tests++;
      if (stu_state !== 2'(ms.state)) begin
        n_fail++;
        $display("FAIL state @edge %0d: got %0d, want %0d", edge_cnt, stu_state, ms.state);
      end
      n_tests++;
      if (stu_drop !== 8'(ms.drop)) begin
        n_fail++;
        $display("FAIL drop @edge %0d: got %0d, want %0d", edge_cnt, stu_drop, ms.drop);
      end
      if (ms.after_rst) begin
        n_tests++;
        if (sm_vld !== 1'b0 || sm_data !== 16'd0) begin
          n_fail++;
          $display("FAIL reset_out @edge %0d: got vld=%0b data=%0d, want vld=0 data=0",
                   edge_cnt, sm_vld, sm_data);
        end
      end
    end
    if (sm_vld === 1'b1) begin
      n_tests++;
      if (out_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out @edge %0d: got sm_vld=1 data=%0d, want no output",
                 edge_cnt, sm_data);
      end else begin
        mo = out_q.pop_front();
        if (mo.edge_no != edge_cnt || sm_data !== 16'(mo.data)) begin
          n_fail++;
          $display("FAIL out_data @edge %0d: got data=%0d, want data=%0d at edge %0d",
                   edge_cnt, sm_data, mo.data, mo.edge_no);
        end
      end
    end else if (out_q.size() > 0 && out_q[0].edge_no <= edge_cnt) begin
      n_tests++;
      n_fail++;
      mo = out_q.pop_front();
      $display("FAIL missing_out @edge %0d: got sm_vld=%0b, want data=%0d", edge_cnt, sm_vld, mo.data);
    end
    if (done) begin
      n_tests++;
      if (out_q.size() != 0 || snap_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: got %0d outputs and %0d states pending, want 0",
                 out_q.size(), snap_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // Stimulus: directed scenarios, randomized traffic, then drop saturation.
  initial begin
    int unsigned cur_k;
    bit          en;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 55, 2);
    step(0, 0, 0, 0, 2);
    step(0, 1, 0, 0, 2);
    for (int i = 1; i <= 5; i++) step(0, 1, 1, 100 * i, 2);
    step(0, 1, 0, 0, 2);
    step(0, 0, 0, 0, 3);
    step(0, 1, 0, 0, 3);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 4095, 3);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 7, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 10, 1);
    step(0, 1, 1, 20, 1);
    step(0, 1, 1, 30, 1);
    step(0, 1, 1, 1000, 3);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 50 * i + 1, 3);
    step(0, 1, 1, 77, 3);
    step(0, 0, 1, 999, 3);
    step(0, 1, 0, 0, 3);
    for (int i = 0; i < 9; i++) step(0, 1, 1, 3 * i + 5, 3);
    step(1, 1, 1, 456, 3);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 2);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 800 + i, 2);
    step(0, 1, 1, 900, 2);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    cur_k = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) cur_k = $urandom_range(0, 3);
      en = ($urandom_range(0, 31) != 0);
      step(($urandom_range(0, 499) == 0), en, ($urandom_range(0, 2) != 0),
           $urandom_range(0, 4095), cur_k);
    end
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 1, i, (i % 2 == 0) ? 1 : 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    done = 1'b1;
    repeat (10) @(posedge clk_sys);
    $display("FAIL timeout: monitor did not reach the summary");
    $fatal(1, "[TB] monitor did not finish");
  end

endmodule
